// File: rtl/axi4_stream_fifo_pkg.sv
// Shared types and helpers for the single-clock AXI4-Stream FIFO family.
//   wr_state_t  : write-side FSM (pass beats / discard rest of an overflowed packet)
//   beat_width  : packed width of one stored beat
//                 (data, strb, keep, last, user, dest, id)
package axi4_stream_fifo_pkg;

  typedef enum logic [0:0] {
    WR_PASS = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  // Width of one beat as stored in RAM. The matching beat_t struct is declared
  // in each user module from its own parameters. This function keeps the RAM
  // width in one place.
  function automatic int beat_width(int data_w, int user_w, int dest_w, int id_w);
    return data_w + 2 * (data_w / 8) + 1 + user_w + dest_w + id_w;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle.
//   master modport : drives tvalid/payload, samples tready
//   slave modport  : samples tvalid/payload, drives tready
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
                  output tready);
endinterface

// File: rtl/axi4_stream_fifo_ram.sv
// Simple dual-port RAM with a registered read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request. rdata updates one clock later and holds
//                  while re=0.
module axi4_stream_fifo_ram
  import axi4_stream_fifo_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi4_stream_sc_pkt_fifo.sv
// Single-clock AXI4-Stream FIFO with optional store-and-forward packet mode.
//   clk_i, rst_i  : clock and synchronous active-high reset
//   used_words_o  : beats held, including uncommitted beats and the output stage
//   pkts_amount_o : complete (tlast-terminated) packets held
//   full_o/empty_o: used_words_o == WORDS_AMOUNT / == 0
//   drop_o        : one pulse per dropped beat (word mode) or per dropped packet
//   slave_if      : input stream
//   master_if     : output stream
module axi4_stream_sc_pkt_fifo
  import axi4_stream_fifo_pkg::*;
#(
  parameter  int WORDS_AMOUNT             = 64,
  parameter  bit PKT_MODE                 = 1,
  parameter  bit ALLOW_SLAVE_BACKPRESSURE = 1,
  parameter  int DATA_WIDTH               = 32,
  parameter  int DEST_WIDTH               = 1,
  parameter  int USER_WIDTH               = 1,
  parameter  int ID_WIDTH                 = 1,
  localparam int ADDR_WIDTH               = $clog2(WORDS_AMOUNT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [ADDR_WIDTH:0] used_words_o,
  output logic [ADDR_WIDTH:0] pkts_amount_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                drop_o,
  axi4_stream_if.slave        slave_if,
  axi4_stream_if.master       master_if
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic [USER_WIDTH-1:0]   user;
    logic [DEST_WIDTH-1:0]   dest;
    logic [ID_WIDTH-1:0]     id;
  } beat_t;

  localparam int BEAT_W = beat_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH, ID_WIDTH);

  wr_state_t           wr_state;
  logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr, used, pkts, rb_words;
  logic                out_valid;
  logic                s_hs, store, ovf, rollback, big_pkt, rd_en, m_hs;
  beat_t               wr_beat, rd_beat;
  logic [BEAT_W-1:0]   rd_raw;

  // used never exceeds WORDS_AMOUNT, so its MSB alone flags full
  assign full_o        = used[ADDR_WIDTH];
  assign empty_o       = (used == '0);
  assign used_words_o  = used;
  assign pkts_amount_o = pkts;

  // Full with no complete packet held: the packet cannot fit, so accept and
  // discard the rest of it instead of stalling forever.
  assign big_pkt = PKT_MODE && (pkts == '0);

  assign slave_if.tready = !rst_i && (wr_state == WR_DROP || !ALLOW_SLAVE_BACKPRESSURE ||
                                      !full_o || big_pkt);

  assign s_hs     = slave_if.tvalid && slave_if.tready;
  assign store    = s_hs && (wr_state == WR_PASS) && !full_o;
  assign ovf      = s_hs && (wr_state == WR_PASS) && full_o;
  assign rollback = ovf && PKT_MODE;
  assign rb_words = rollback ? (wr_ptr - commit_ptr) : '0;

  assign drop_o = (ovf && (!PKT_MODE || slave_if.tlast)) ||
                  (s_hs && (wr_state == WR_DROP) && slave_if.tlast);

  assign wr_beat = '{data: slave_if.tdata, strb: slave_if.tstrb, keep: slave_if.tkeep,
                     last: slave_if.tlast, user: slave_if.tuser, dest: slave_if.tdest,
                     id: slave_if.tid};

  // The RAM read register is the output stage. A new read is issued only
  // when that stage is empty or being drained, so the payload holds under
  // backpressure. Reading ahead on every handshake gives one beat per clock.
  assign m_hs  = out_valid && master_if.tready;
  assign rd_en = (rd_ptr != commit_ptr) && (!out_valid || master_if.tready);

  axi4_stream_fifo_ram #(.WIDTH(BEAT_W), .DEPTH(WORDS_AMOUNT)) u_ram (
    .clk   (clk_i),
    .we    (store),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_beat),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_raw)
  );

  assign rd_beat          = rd_raw;
  assign master_if.tvalid = out_valid;
  assign master_if.tdata  = rd_beat.data;
  assign master_if.tstrb  = rd_beat.strb;
  assign master_if.tkeep  = rd_beat.keep;
  assign master_if.tlast  = rd_beat.last;
  assign master_if.tuser  = rd_beat.user;
  assign master_if.tdest  = rd_beat.dest;
  assign master_if.tid    = rd_beat.id;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state   <= WR_PASS;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      used       <= '0;
      pkts       <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
        // The read side only ever sees commit_ptr. Packet mode publishes a
        // whole packet at its tlast.
        if (!PKT_MODE || slave_if.tlast) commit_ptr <= wr_ptr + 1'b1;
      end else if (rollback) begin
        wr_ptr <= commit_ptr;
      end

      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      if (rd_en)     out_valid <= 1'b1;
      else if (m_hs) out_valid <= 1'b0;

      used <= used + {{ADDR_WIDTH{1'b0}}, store} - {{ADDR_WIDTH{1'b0}}, m_hs} - rb_words;
      pkts <= pkts + {{ADDR_WIDTH{1'b0}}, store && slave_if.tlast}
                   - {{ADDR_WIDTH{1'b0}}, m_hs && rd_beat.last};

      case (wr_state)
        WR_PASS: if (rollback && !slave_if.tlast) wr_state <= WR_DROP;
        WR_DROP: if (s_hs && slave_if.tlast)      wr_state <= WR_PASS;
        default:                                  wr_state <= WR_PASS;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_stream_sc_pkt_fifo.sv
// Directed bench. Four FIFO configurations run side by side:
//   0: depth 16, word mode,   backpressure
//   1: depth 8,  packet mode, backpressure
//   2: depth 8,  packet mode, overflow drop
//   3: depth 4,  word mode,   overflow drop
// Inputs change 1ns after posedge. Monitors sample on negedge.
module tb_axi4_stream_sc_pkt_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s_valid = '0, s_last = '0, m_ready = '0;
  logic [7:0] s_data [4];
  logic [7:0] used_w [4], pkts_w [4], m_data [4];
  logic [3:0] m_valid, m_last, s_ready, full_w, empty_w, drop_w;
  int checks = 0, errors = 0;
  int base, d0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int D  = (k == 0) ? 16 : (k == 3) ? 4 : 8;
    localparam int AW = $clog2(D);
    axi4_stream_if #(.DATA_WIDTH(8)) s_if ();
    axi4_stream_if #(.DATA_WIDTH(8)) m_if ();
    logic [AW:0] used, pkts;
    logic        full, empty, drop;
    int          rxn = 0, dcnt = 0, sberr = 0;
    logic [7:0]  rx  [32];
    logic        rxl [32];

    // sideband carries copies of data bits so pass-through can be checked
    assign s_if.tvalid = s_valid[k];
    assign s_if.tdata  = s_data[k];
    assign s_if.tlast  = s_last[k];
    assign s_if.tuser  = s_data[k][0];
    assign s_if.tdest  = s_data[k][1];
    assign s_if.tid    = s_data[k][2];
    assign s_if.tstrb  = s_data[k][3];
    assign s_if.tkeep  = s_data[k][4];
    assign m_if.tready = m_ready[k];

    assign used_w[k]  = 8'(used);
    assign pkts_w[k]  = 8'(pkts);
    assign m_data[k]  = m_if.tdata;
    assign m_valid[k] = m_if.tvalid;
    assign m_last[k]  = m_if.tlast;
    assign s_ready[k] = s_if.tready;
    assign full_w[k]  = full;
    assign empty_w[k] = empty;
    assign drop_w[k]  = drop;

    axi4_stream_sc_pkt_fifo #(
      .WORDS_AMOUNT(D), .PKT_MODE(k == 1 || k == 2), .ALLOW_SLAVE_BACKPRESSURE(k < 2),
      .DATA_WIDTH(8), .DEST_WIDTH(1), .USER_WIDTH(1), .ID_WIDTH(1)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .used_words_o(used), .pkts_amount_o(pkts),
      .full_o(full), .empty_o(empty), .drop_o(drop), .slave_if(s_if), .master_if(m_if)
    );

    always @(negedge clk) begin
      if (m_if.tvalid && m_if.tready) begin
        rx[rxn[4:0]]  <= m_if.tdata;
        rxl[rxn[4:0]] <= m_if.tlast;
        rxn           <= rxn + 1;
        if (m_if.tuser !== m_if.tdata[0] || m_if.tdest !== m_if.tdata[1] ||
            m_if.tid !== m_if.tdata[2] || m_if.tstrb !== m_if.tdata[3] ||
            m_if.tkeep !== m_if.tdata[4])
          sberr <= sberr + 1;
      end
      if (drop) dcnt <= dcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int k, input logic [7:0] d, input logic l);
    s_valid[k] = 1'b1;
    s_data[k]  = d;
    s_last[k]  = l;
    step();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) s_data[k] = 8'h00;
    repeat (3) step();
    // reset state
    chk("rst_tready", 32'(s_ready), 0);
    chk("rst_tvalid", 32'(m_valid), 0);
    chk("rst_empty", 32'(empty_w), 32'hF);
    chk("rst_full", 32'(full_w), 0);
    chk("rst_drop", 32'(drop_w), 0);
    chk("rst_used0", 32'(used_w[0]), 0);
    chk("rst_pkts1", 32'(pkts_w[1]), 0);
    rst = 1'b0;
    step();

    // 1: word mode fills to 16 under master stall, then drains in order
    for (int i = 0; i < 16; i++) drive(0, 8'h10 + 8'(i), (i == 7 || i == 15));
    s_data[0] = 8'hEE;
    s_last[0] = 1'b0;
    mid();
    chk("t1_tready_full", 32'(s_ready[0]), 0);
    chk("t1_full", 32'(full_w[0]), 1);
    chk("t1_used", 32'(used_w[0]), 16);
    chk("t1_pkts", 32'(pkts_w[0]), 2);
    chk("t1_tvalid", 32'(m_valid[0]), 1);
    chk("t1_head", 32'(m_data[0]), 32'h10);
    step();
    chk("t1_used_stall", 32'(used_w[0]), 16);
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b1;
    repeat (16) step();
    chk("t1_rx_count", g_dut[0].rxn, 16);
    chk("t1_empty", 32'(empty_w[0]), 1);
    chk("t1_pkts_end", 32'(pkts_w[0]), 0);
    for (int i = 0; i < 16; i++) chk("t1_rx_data", 32'(g_dut[0].rx[i]), 32'h10 + 32'(i));
    chk("t1_last7", 32'(g_dut[0].rxl[7]), 1);
    chk("t1_last15", 32'(g_dut[0].rxl[15]), 1);

    // 2: packet mode hides the packet until tlast, then 3 contiguous beats
    m_ready[1] = 1'b1;
    drive(1, 8'hA1, 1'b0);
    drive(1, 8'hA2, 1'b0);
    s_data[1] = 8'hA3;
    s_last[1] = 1'b1;
    mid();
    chk("t2_hidden_n", 32'(m_valid[1]), 0);
    step();
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    mid();
    chk("t2_hidden_n1", 32'(m_valid[1]), 0);
    chk("t2_pkts1", 32'(pkts_w[1]), 1);
    chk("t2_used3", 32'(used_w[1]), 3);
    step();
    mid();
    chk("t2_valid_n2", 32'(m_valid[1]), 1);
    chk("t2_beat0", 32'(m_data[1]), 32'hA1);
    step();
    mid();
    chk("t2_valid_n3", 32'(m_valid[1]), 1);
    chk("t2_beat1", 32'(m_data[1]), 32'hA2);
    step();
    mid();
    chk("t2_beat2", 32'(m_data[1]), 32'hA3);
    chk("t2_tlast", 32'(m_last[1]), 1);
    chk("t2_pkts_hold", 32'(pkts_w[1]), 1);
    step();
    chk("t2_pkts0", 32'(pkts_w[1]), 0);
    chk("t2_used0", 32'(used_w[1]), 0);
    chk("t2_tvalid0", 32'(m_valid[1]), 0);
    chk("t2_rx_count", g_dut[1].rxn, 3);

    // 3: 12-beat packet into depth 8 with backpressure is discarded
    d0 = g_dut[1].dcnt;
    for (int i = 0; i < 8; i++) drive(1, 8'hB0 + 8'(i), 1'b0);
    s_data[1] = 8'hB8;
    mid();
    chk("t3_used8", 32'(used_w[1]), 8);
    chk("t3_full", 32'(full_w[1]), 1);
    chk("t3_tready_big", 32'(s_ready[1]), 1);
    chk("t3_hidden", 32'(m_valid[1]), 0);
    step();
    chk("t3_rollback", 32'(used_w[1]), 0);
    for (int i = 9; i < 12; i++) drive(1, 8'hB0 + 8'(i), (i == 11));
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    chk("t3_drop_pulses", g_dut[1].dcnt - d0, 1);
    chk("t3_used_after", 32'(used_w[1]), 0);
    chk("t3_pkts_after", 32'(pkts_w[1]), 0);
    for (int i = 0; i < 4; i++) drive(1, 8'hC0 + 8'(i), (i == 3));
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    repeat (6) step();
    chk("t3_rx_count", g_dut[1].rxn, 7);
    for (int i = 0; i < 4; i++) chk("t3_rx_data", 32'(g_dut[1].rx[3+i]), 32'hC0 + 32'(i));

    // 4: no backpressure, packet mode: second packet overflows and is dropped
    d0 = g_dut[2].dcnt;
    drive(2, 8'h40, 1'b0);
    drive(2, 8'h41, 1'b1);
    for (int i = 0; i < 6; i++) drive(2, 8'h50 + 8'(i), 1'b0);
    s_data[2] = 8'h56;
    mid();
    chk("t4_full", 32'(full_w[2]), 1);
    chk("t4_tready", 32'(s_ready[2]), 1);
    chk("t4_used8", 32'(used_w[2]), 8);
    step();
    chk("t4_rollback", 32'(used_w[2]), 2);
    drive(2, 8'h57, 1'b1);
    s_valid[2] = 1'b0;
    s_last[2]  = 1'b0;
    chk("t4_drop_pulses", g_dut[2].dcnt - d0, 1);
    chk("t4_used2", 32'(used_w[2]), 2);
    chk("t4_pkts1", 32'(pkts_w[2]), 1);
    chk("t4_head", 32'(m_data[2]), 32'h40);
    m_ready[2] = 1'b1;
    repeat (4) step();
    chk("t4_rx_count", g_dut[2].rxn, 2);
    chk("t4_rx0", 32'(g_dut[2].rx[0]), 32'h40);
    chk("t4_rx1", 32'(g_dut[2].rx[1]), 32'h41);
    chk("t4_used_end", 32'(used_w[2]), 0);

    // 5: no backpressure, word mode, depth 4: beats 5 and 6 dropped
    d0 = g_dut[3].dcnt;
    for (int i = 0; i < 6; i++) drive(3, 8'h60 + 8'(i), (i == 3 || i == 5));
    s_valid[3] = 1'b0;
    s_last[3]  = 1'b0;
    chk("t5_drop_pulses", g_dut[3].dcnt - d0, 2);
    chk("t5_used4", 32'(used_w[3]), 4);
    chk("t5_pkts1", 32'(pkts_w[3]), 1);
    chk("t5_full", 32'(full_w[3]), 1);
    m_ready[3] = 1'b1;
    repeat (6) step();
    chk("t5_rx_count", g_dut[3].rxn, 4);
    for (int i = 0; i < 4; i++) chk("t5_rx_data", 32'(g_dut[3].rx[i]), 32'h60 + 32'(i));
    chk("t5_last", 32'(g_dut[3].rxl[3]), 1);
    chk("t5_pkts_end", 32'(pkts_w[3]), 0);

    // 6: reset mid-packet with a committed packet held
    m_ready[1] = 1'b0;
    drive(1, 8'hD0, 1'b0);
    drive(1, 8'hD1, 1'b1);
    drive(1, 8'hD2, 1'b0);
    s_valid[1] = 1'b0;
    repeat (3) step();
    chk("t6_used3", 32'(used_w[1]), 3);
    chk("t6_pkts1", 32'(pkts_w[1]), 1);
    chk("t6_tvalid", 32'(m_valid[1]), 1);
    d0 = g_dut[1].dcnt;
    rst = 1'b1;
    mid();
    chk("t6_tready_rst", 32'(s_ready[1]), 0);
    step();
    rst = 1'b0;
    chk("t6_used0", 32'(used_w[1]), 0);
    chk("t6_pkts0", 32'(pkts_w[1]), 0);
    chk("t6_tvalid0", 32'(m_valid[1]), 0);
    chk("t6_empty", 32'(empty_w[1]), 1);
    mid();
    chk("t6_no_drop", g_dut[1].dcnt - d0, 0);
    base = g_dut[1].rxn;
    m_ready[1] = 1'b1;
    step();
    drive(1, 8'hE0, 1'b0);
    drive(1, 8'hE1, 1'b1);
    s_valid[1] = 1'b0;
    s_last[1]  = 1'b0;
    repeat (5) step();
    chk("t6_rx_count", g_dut[1].rxn - base, 2);
    chk("t6_rx0", 32'(g_dut[1].rx[base]), 32'hE0);
    chk("t6_rx1", 32'(g_dut[1].rx[base+1]), 32'hE1);

    chk("sideband0", g_dut[0].sberr, 0);
    chk("sideband1", g_dut[1].sberr, 0);
    chk("sideband2", g_dut[2].sberr, 0);
    chk("sideband3", g_dut[3].sberr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
